// File: rtl/kamus_pkg.sv
// Shared core types: decoded memory operations, access widths and LSU states,
// plus small decode helpers used by the load/store path.
package kamus_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
        OP_SB, OP_SH, OP_SW
    } operation_e;

    typedef enum logic [1:0] {MW_B, MW_H, MW_W} mem_width_e;

    typedef enum logic [1:0] {LSU_IDLE, LSU_REQ, LSU_WAIT, LSU_DRAIN} lsu_state_e;

    function automatic mem_width_e op_to_width(operation_e op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return MW_B;
            OP_LH, OP_LHU, OP_SH: return MW_H;
            default:              return MW_W;
        endcase
    endfunction

    function automatic logic op_is_load(operation_e op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    endfunction

    function automatic logic op_is_store(operation_e op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic logic op_is_signed(operation_e op);
        return op inside {OP_LB, OP_LH};
    endfunction

endpackage

// File: rtl/kamus_lsu_align.sv
// Byte-lane steering: store byte enables / data replication and load lane
// extraction with sign or zero extension. Purely combinational.
module kamus_lsu_align
    import kamus_pkg::*;
(
    input  mem_width_e  st_width_i,
    input  logic [1:0]  st_off_i,
    input  logic [31:0] st_data_i,
    output logic [3:0]  st_be_o,
    output logic [31:0] st_wdata_o,
    input  mem_width_e  ld_width_i,
    input  logic        ld_signed_i,
    input  logic [1:0]  ld_off_i,
    input  logic [31:0] ld_data_i,
    output logic [31:0] ld_data_o
);
    logic [31:0] ld_shifted;

    always_comb begin
        st_be_o    = 4'b1111;
        st_wdata_o = st_data_i;
        case (st_width_i)
            MW_B: begin
                st_be_o    = 4'b0001 << st_off_i;
                st_wdata_o = {4{st_data_i[7:0]}};
            end
            MW_H: begin
                st_be_o    = st_off_i[1] ? 4'b1100 : 4'b0011;
                st_wdata_o = {2{st_data_i[15:0]}};
            end
            default: ;
        endcase
    end

    // Aligned words always have offset 0, so the shifted word is the word itself.
    always_comb begin
        ld_shifted = ld_data_i >> {ld_off_i, 3'b000};
        ld_data_o  = ld_shifted;
        case (ld_width_i)
            MW_B: ld_data_o = {{24{ld_signed_i & ld_shifted[7]}}, ld_shifted[7:0]};
            MW_H: ld_data_o = {{16{ld_signed_i & ld_shifted[15]}}, ld_shifted[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/kamus_lsu_ctrl.sv
// Load/store sequencer: one op at a time from EX, alignment check, L1 req/gnt/rvalid
// handshake with timeout and flush abort, single-cycle response to writeback.
module kamus_lsu_ctrl
    import kamus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  operation_e  op_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  rd_addr_i,
    input  logic        flush_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic [4:0]  rsp_rd_addr_o,
    output logic        misalign_o,
    output logic        bus_err_o,
    output logic [31:0] fault_addr_o
);
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    lsu_state_e  state_q, state_d;
    operation_e  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [4:0]  rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic        dreq_q, dreq_d, dwe_q, dwe_d;
    logic [3:0]  dbe_q, dbe_d;
    logic [31:0] daddr_q, daddr_d, dwdata_q, dwdata_d;
    logic        rsp_valid_q, rsp_valid_d, mis_q, mis_d, err_q, err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d, fault_q, fault_d;
    logic [4:0]  rsp_rd_q, rsp_rd_d;

    logic [3:0]  st_be;
    logic [31:0] st_wdata, ld_ext;
    logic        mem_in, mis_in, timeout, fin_st, fin_ld, fin_err;
    mem_width_e  w_in;

    kamus_lsu_align u_align (
        .st_width_i  (w_in),
        .st_off_i    (addr_i[1:0]),
        .st_data_i   (wdata_i),
        .st_be_o     (st_be),
        .st_wdata_o  (st_wdata),
        .ld_width_i  (op_to_width(op_q)),
        .ld_signed_i (op_is_signed(op_q)),
        .ld_off_i    (addr_q[1:0]),
        .ld_data_i   (dmem_rdata_i),
        .ld_data_o   (ld_ext)
    );

    always_comb begin
        w_in    = op_to_width(op_i);
        mem_in  = op_is_load(op_i) || op_is_store(op_i);
        mis_in  = (w_in == MW_H && addr_i[0]) || (w_in == MW_W && addr_i[1:0] != 2'b00);
        timeout = (TIMEOUT_CYCLES > 0) && (cnt_q == CNT_LAST);

        state_d = state_q;  op_d = op_q;  addr_d = addr_q;  rd_d = rd_q;  cnt_d = cnt_q;
        dreq_d = dreq_q;  dwe_d = dwe_q;  dbe_d = dbe_q;  daddr_d = daddr_q;  dwdata_d = dwdata_q;
        rsp_valid_d = 1'b0;  rsp_rdata_d = rsp_rdata_q;  rsp_rd_d = rsp_rd_q;
        mis_d = mis_q;  err_d = err_q;  fault_d = fault_q;
        fin_st = 1'b0;  fin_ld = 1'b0;  fin_err = 1'b0;

        case (state_q)
            LSU_IDLE: begin
                if (req_valid_i && !flush_i) begin
                    if (!mem_in || mis_in) begin
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = '0;
                        rsp_rd_d    = '0;
                        mis_d       = mem_in;
                        err_d       = !mem_in;
                        fault_d     = addr_i;
                    end else begin
                        state_d  = LSU_REQ;
                        op_d     = op_i;
                        addr_d   = addr_i;
                        rd_d     = rd_addr_i;
                        cnt_d    = '0;
                        dreq_d   = 1'b1;
                        dwe_d    = op_is_store(op_i);
                        dbe_d    = st_be;
                        daddr_d  = {addr_i[31:2], 2'b00};
                        dwdata_d = st_wdata;
                    end
                end
            end
            LSU_REQ: begin
                cnt_d = cnt_q + 1'b1;
                if (flush_i) begin
                    // A granted load still owes us an rvalid unless it came this cycle.
                    dreq_d  = 1'b0;
                    state_d = (dmem_gnt_i && op_is_load(op_q) && !dmem_rvalid_i) ? LSU_DRAIN : LSU_IDLE;
                end else if (dmem_gnt_i) begin
                    dreq_d = 1'b0;
                    if (!op_is_load(op_q)) begin
                        fin_st  = 1'b1;
                        state_d = LSU_IDLE;
                    end else if (dmem_rvalid_i) begin
                        fin_ld  = 1'b1;
                        state_d = LSU_IDLE;
                    end else if (timeout) begin
                        fin_err = 1'b1;
                        state_d = LSU_DRAIN;
                    end else begin
                        state_d = LSU_WAIT;
                    end
                end else if (timeout) begin
                    dreq_d  = 1'b0;
                    fin_err = 1'b1;
                    state_d = LSU_IDLE;
                end
            end
            LSU_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (flush_i) begin
                    state_d = dmem_rvalid_i ? LSU_IDLE : LSU_DRAIN;
                end else if (dmem_rvalid_i) begin
                    fin_ld  = 1'b1;
                    state_d = LSU_IDLE;
                end else if (timeout) begin
                    fin_err = 1'b1;
                    state_d = LSU_DRAIN;
                end
            end
            LSU_DRAIN: begin
                if (dmem_rvalid_i) state_d = LSU_IDLE;
            end
            default: state_d = LSU_IDLE;
        endcase

        if (fin_st || fin_ld || fin_err) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = fin_ld ? ld_ext : '0;
            rsp_rd_d    = fin_ld ? rd_q : '0;
            mis_d       = 1'b0;
            err_d       = fin_err;
            if (fin_err) fault_d = addr_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= LSU_IDLE;  op_q <= OP_NOP;  addr_q <= '0;  rd_q <= '0;  cnt_q <= '0;
            dreq_q <= 1'b0;  dwe_q <= 1'b0;  dbe_q <= '0;  daddr_q <= '0;  dwdata_q <= '0;
            rsp_valid_q <= 1'b0;  rsp_rdata_q <= '0;  rsp_rd_q <= '0;
            mis_q <= 1'b0;  err_q <= 1'b0;  fault_q <= '0;
        end else begin
            state_q <= state_d;  op_q <= op_d;  addr_q <= addr_d;  rd_q <= rd_d;  cnt_q <= cnt_d;
            dreq_q <= dreq_d;  dwe_q <= dwe_d;  dbe_q <= dbe_d;  daddr_q <= daddr_d;  dwdata_q <= dwdata_d;
            rsp_valid_q <= rsp_valid_d;  rsp_rdata_q <= rsp_rdata_d;  rsp_rd_q <= rsp_rd_d;
            mis_q <= mis_d;  err_q <= err_d;  fault_q <= fault_d;
        end
    end

    assign req_ready_o   = (state_q == LSU_IDLE);
    assign dmem_req_o    = dreq_q;
    assign dmem_we_o     = dwe_q;
    assign dmem_be_o     = dbe_q;
    assign dmem_addr_o   = daddr_q;
    assign dmem_wdata_o  = dwdata_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rsp_rdata_q;
    assign rsp_rd_addr_o = rsp_rd_q;
    assign misalign_o    = mis_q;
    assign bus_err_o     = err_q;
    assign fault_addr_o  = fault_q;

endmodule

// File: tb/tb_kamus_lsu_ctrl.sv
// Bench for kamus_lsu_ctrl: directed vector table plus random transactions checked
// against a cycle-arithmetic reference model, and an asynchronous reset sequence.
module tb_kamus_lsu_ctrl;
    import kamus_pkg::*;

    localparam int T     = 4;
    localparam int WIN   = 12;
    localparam int NEVER = 99;

    logic        clk_i = 1'b0, rst_i = 1'b1;
    logic        req_valid_i = 1'b0, req_ready_o;
    operation_e  op_i = OP_NOP;
    logic [31:0] addr_i = '0, wdata_i = '0;
    logic [4:0]  rd_addr_i = '0;
    logic        flush_i = 1'b0;
    logic        dmem_req_o, dmem_we_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic        dmem_gnt_i = 1'b0, dmem_rvalid_i = 1'b0;
    logic [31:0] dmem_rdata_i = '0;
    logic        rsp_valid_o, misalign_o, bus_err_o;
    logic [31:0] rsp_rdata_o, fault_addr_o;
    logic [4:0]  rsp_rd_addr_o;

    always #5 clk_i = ~clk_i;

    kamus_lsu_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .op_i(op_i), .addr_i(addr_i), .wdata_i(wdata_i), .rd_addr_i(rd_addr_i), .flush_i(flush_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_be_o(dmem_be_o),
        .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i),
        .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i), .rsp_valid_o(rsp_valid_o),
        .rsp_rdata_o(rsp_rdata_o), .rsp_rd_addr_o(rsp_rd_addr_o), .misalign_o(misalign_o),
        .bus_err_o(bus_err_o), .fault_addr_o(fault_addr_o)
    );

    // g: req cycles before gnt; r: cycles from gnt to rvalid; f: flush cycle (0 = accept cycle)
    typedef struct {
        operation_e  op;
        logic [31:0] addr, wdata, rdata;
        logic [4:0]  rd;
        int          g, r, f;
        int          reqs, rsp, rsp_at, ready_at;
        logic        mis, err, we;
        logic [31:0] rdata_x, fault, daddr, dwdata;
        logic [4:0]  rd_x;
        logic [3:0]  be;
    } vec_t;

    int total = 0, bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic bit is_ld(operation_e op);
        return op == OP_LB || op == OP_LH || op == OP_LW || op == OP_LBU || op == OP_LHU;
    endfunction
    function automatic bit is_st(operation_e op);
        return op == OP_SB || op == OP_SH || op == OP_SW;
    endfunction

    function automatic vec_t dv(operation_e op, logic [31:0] addr, logic [31:0] wdata,
                                logic [31:0] rdata, logic [4:0] rd, int g, int r, int f,
                                int reqs, int rsp, int rsp_at, logic mis, logic err,
                                logic [31:0] rdata_x, logic [4:0] rd_x, logic [31:0] fault,
                                logic [3:0] be, logic [31:0] daddr, logic we,
                                logic [31:0] dwdata, int ready_at);
        vec_t v;
        v.op = op; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.rd = rd;
        v.g = g; v.r = r; v.f = f; v.reqs = reqs; v.rsp = rsp; v.rsp_at = rsp_at;
        v.mis = mis; v.err = err; v.rdata_x = rdata_x; v.rd_x = rd_x; v.fault = fault;
        v.be = be; v.daddr = daddr; v.we = we; v.dwdata = dwdata; v.ready_at = ready_at;
        return v;
    endfunction

    // Reference: event cycles relative to the accept cycle 0, REQ entry at cycle 1.
    function automatic vec_t model(input vec_t v);
        vec_t e = v;
        bit ld = is_ld(v.op), st = is_st(v.op);
        int sz = (v.op == OP_LB || v.op == OP_LBU || v.op == OP_SB) ? 1 :
                 (v.op == OP_LH || v.op == OP_LHU || v.op == OP_SH) ? 2 : 4;
        int off = int'(v.addr[1:0]);
        int gc = 1 + v.g, rc = 1 + v.g + v.r;
        int c = ld ? rc : gc;
        longint val, full;
        e.rsp = 0; e.rsp_at = 0; e.mis = 0; e.err = 0; e.rdata_x = 0; e.rd_x = 0;
        e.fault = v.addr; e.reqs = 0; e.ready_at = 1; e.we = st;
        e.be = 4'(((1 << sz) - 1) << off);
        e.daddr = v.addr & 32'hFFFF_FFFC;
        e.dwdata = (sz == 1) ? v.wdata[7:0] * 32'h0101_0101 :
                   (sz == 2) ? v.wdata[15:0] * 32'h0001_0001 : v.wdata;
        if (v.f == 0) return e;
        if (!(ld || st) || (off % sz) != 0) begin
            e.rsp = 1; e.rsp_at = 1; e.mis = ld || st; e.err = !(ld || st);
            return e;
        end
        if (v.f <= c && v.f <= T) begin
            e.reqs = (gc < v.f) ? gc : v.f;
            e.ready_at = (ld && gc <= v.f && rc > v.f) ? rc + 1 : v.f + 1;
        end else if (c <= T) begin
            e.reqs = gc; e.rsp = 1; e.rsp_at = c + 1; e.ready_at = c + 1;
            if (ld) begin
                full = longint'(1) << (8 * sz);
                val = longint'(v.rdata >> (8 * off)) % full;
                if ((v.op == OP_LB || v.op == OP_LH) && val >= full / 2) val = val - full;
                e.rdata_x = 32'(val);
                e.rd_x = v.rd;
            end
        end else begin
            e.reqs = (gc < T) ? gc : T;
            e.rsp = 1; e.rsp_at = T + 1; e.err = 1;
            e.ready_at = (ld && gc <= T) ? rc + 1 : T + 1;
        end
        return e;
    endfunction

    // Entered #1 after a rising edge; that cycle becomes the accept cycle.
    task automatic run(input vec_t e, input string tag);
        int reqs = 0, rsps = 0, rsp_at = -1, ready_at = -1, unstable = 0;
        bit granted = 0;
        logic [3:0]  be_s = '0;
        logic [31:0] da_s = '0, dw_s = '0, rdat_s = '0, flt_s = '0;
        logic        we_s = 1'b0, m_s = 1'b0, e_s = 1'b0;
        logic [4:0]  rd_s = '0;
        for (int k = 0; k <= WIN; k++) begin
            if (k > 0) begin
                if (dmem_req_o) begin
                    if (reqs == 0) begin
                        be_s = dmem_be_o; da_s = dmem_addr_o; we_s = dmem_we_o; dw_s = dmem_wdata_o;
                    end else if ({dmem_be_o, dmem_addr_o, dmem_we_o, dmem_wdata_o} !== {be_s, da_s, we_s, dw_s})
                        unstable++;
                    reqs++;
                end
                if (rsp_valid_o) begin
                    if (rsps == 0) begin
                        rsp_at = k; m_s = misalign_o; e_s = bus_err_o;
                        rdat_s = rsp_rdata_o; rd_s = rsp_rd_addr_o; flt_s = fault_addr_o;
                    end
                    rsps++;
                end
                if (req_ready_o && ready_at < 0) ready_at = k;
            end
            req_valid_i  = (k == 0);
            op_i         = e.op;
            addr_i       = e.addr;
            wdata_i      = e.wdata;
            rd_addr_i    = e.rd;
            flush_i      = (k == e.f);
            dmem_gnt_i   = dmem_req_o && (k == 1 + e.g);
            if (dmem_gnt_i) granted = 1;
            dmem_rvalid_i = granted && is_ld(e.op) && (k == 1 + e.g + e.r);
            dmem_rdata_i = e.rdata;
            @(posedge clk_i); #1;
        end
        req_valid_i = 0; flush_i = 0; dmem_gnt_i = 0; dmem_rvalid_i = 0; op_i = OP_NOP;
        chk({tag, " reqs"}, reqs, e.reqs);
        chk({tag, " rsp_count"}, rsps, e.rsp);
        chk({tag, " ready_at"}, ready_at, e.ready_at);
        if (e.rsp > 0) begin
            chk({tag, " rsp_at"}, rsp_at, e.rsp_at);
            chk({tag, " misalign"}, m_s, e.mis);
            chk({tag, " bus_err"}, e_s, e.err);
            chk({tag, " rdata"}, rdat_s, e.rdata_x);
            chk({tag, " rd"}, rd_s, e.rd_x);
            if (e.mis || e.err) chk({tag, " fault"}, flt_s, e.fault);
        end
        if (e.reqs > 0) begin
            chk({tag, " be"}, be_s, e.be);
            chk({tag, " daddr"}, da_s, e.daddr);
            chk({tag, " we"}, we_s, e.we);
            if (e.we) chk({tag, " wdata"}, dw_s, e.dwdata);
            chk({tag, " stable"}, unstable, 0);
        end
    endtask

    vec_t dir[$];

    initial begin
        vec_t v;
        int nrsp;

        dir.push_back(dv(OP_SW, 32'h1000_0008, 32'hDEAD_BEEF, 0, 7, 2, 0, NEVER,
                         3, 1, 4, 0, 0, 0, 0, 0, 4'hF, 32'h1000_0008, 1, 32'hDEAD_BEEF, 4));
        dir.push_back(dv(OP_LB, 32'h1000_0003, 0, 32'h80AA_BBCC, 5, 0, 1, NEVER,
                         1, 1, 3, 0, 0, 32'hFFFF_FF80, 5, 0, 4'h8, 32'h1000_0000, 0, 0, 3));
        dir.push_back(dv(OP_LBU, 32'h1000_0003, 0, 32'h80AA_BBCC, 5, 0, 1, NEVER,
                         1, 1, 3, 0, 0, 32'h0000_0080, 5, 0, 4'h8, 32'h1000_0000, 0, 0, 3));
        dir.push_back(dv(OP_LH, 32'h1000_0001, 0, 0, 3, 0, 0, NEVER,
                         0, 1, 1, 1, 0, 0, 0, 32'h1000_0001, 0, 0, 0, 0, 1));
        dir.push_back(dv(OP_LW, 32'h2000_0000, 0, 0, 9, NEVER, 0, NEVER,
                         4, 1, 5, 0, 1, 0, 0, 32'h2000_0000, 4'hF, 32'h2000_0000, 0, 0, 5));
        dir.push_back(dv(OP_LW, 32'h3000_0004, 0, 32'h1111_2222, 4, 0, 4, 2,
                         1, 0, 0, 0, 0, 0, 0, 0, 4'hF, 32'h3000_0004, 0, 0, 6));
        dir.push_back(dv(OP_NOP, 32'h0000_0040, 0, 0, 1, 0, 0, NEVER,
                         0, 1, 1, 0, 1, 0, 0, 32'h0000_0040, 0, 0, 0, 0, 1));
        dir.push_back(dv(OP_SH, 32'h0000_0002, 32'h1234_5678, 0, 2, 0, 0, NEVER,
                         1, 1, 2, 0, 0, 0, 0, 0, 4'hC, 32'h0, 1, 32'h5678_5678, 2));
        dir.push_back(dv(OP_SB, 32'h0000_0001, 32'h0000_00AB, 0, 2, 1, 0, NEVER,
                         2, 1, 3, 0, 0, 0, 0, 0, 4'h2, 32'h0, 1, 32'hABAB_ABAB, 3));
        dir.push_back(dv(OP_LH, 32'h0000_0002, 0, 32'h8001_7FFF, 6, 0, 0, NEVER,
                         1, 1, 2, 0, 0, 32'hFFFF_8001, 6, 0, 4'hC, 32'h0, 0, 0, 2));
        dir.push_back(dv(OP_LHU, 32'h0000_0002, 0, 32'h8001_7FFF, 6, 0, 0, NEVER,
                         1, 1, 2, 0, 0, 32'h0000_8001, 6, 0, 4'hC, 32'h0, 0, 0, 2));
        dir.push_back(dv(OP_LW, 32'h0000_0006, 0, 0, 6, 0, 0, NEVER,
                         0, 1, 1, 1, 0, 0, 0, 32'h0000_0006, 0, 0, 0, 0, 1));
        dir.push_back(dv(OP_SW, 32'h0000_0100, 32'h5, 0, 0, 0, 0, 0,
                         0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        dir.push_back(dv(OP_LW, 32'h5000_0000, 0, 32'h77, 8, 1, 5, NEVER,
                         2, 1, 5, 0, 1, 0, 0, 32'h5000_0000, 4'hF, 32'h5000_0000, 0, 0, 8));
        dir.push_back(dv(OP_LW, 32'h0000_0008, 0, 32'hCAFE_F00D, 10, 3, 0, NEVER,
                         4, 1, 5, 0, 0, 32'hCAFE_F00D, 10, 0, 4'hF, 32'h8, 0, 0, 5));

        #2;
        chk("reset ready", req_ready_o, 1);
        chk("reset dmem_req", dmem_req_o, 0);
        chk("reset rsp_valid", rsp_valid_o, 0);
        chk("reset be", dmem_be_o, 0);
        @(negedge clk_i); rst_i = 0;
        @(posedge clk_i); #1;

        foreach (dir[i]) run(dir[i], $sformatf("dir%0d", i));

        for (int n = 0; n < 150; n++) begin
            v.op    = operation_e'($urandom_range(0, 8));
            v.addr  = $urandom;
            v.wdata = $urandom;
            v.rdata = $urandom;
            v.rd    = 5'($urandom_range(1, 31));
            v.g     = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, 3));
            v.r     = $urandom_range(0, 4);
            v.f     = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : NEVER;
            run(model(v), $sformatf("rnd%0d", n));
        end

        // Asynchronous reset while a load is waiting for data.
        req_valid_i = 1; op_i = OP_LW; addr_i = 32'h0000_0010; rd_addr_i = 5'd3;
        @(posedge clk_i); #1;
        req_valid_i = 0; dmem_gnt_i = dmem_req_o;
        @(posedge clk_i); #1;
        dmem_gnt_i = 0;
        chk("rstseq in_wait ready", req_ready_o, 0);
        #2 rst_i = 1;
        #1;
        chk("rstseq ready", req_ready_o, 1);
        chk("rstseq dmem_req", dmem_req_o, 0);
        chk("rstseq daddr", dmem_addr_o, 0);
        chk("rstseq rsp_rdata", rsp_rdata_o, 0);
        chk("rstseq fault", fault_addr_o, 0);
        chk("rstseq rd", rsp_rd_addr_o, 0);
        @(negedge clk_i); rst_i = 0;
        @(posedge clk_i); #1;
        dmem_rvalid_i = 1; dmem_rdata_i = 32'h1234_5678;
        nrsp = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk_i); #1;
            dmem_rvalid_i = 0;
            if (rsp_valid_o) nrsp++;
        end
        chk("rstseq no_rsp", nrsp, 0);
        chk("rstseq ready_after", req_ready_o, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/kamus_lsu_ctrl.md
Name: kamus_lsu_ctrl

Overview:
- Load/store sequencer between the EX stage and the L1 data memory port.
- Accepts one decoded memory operation at a time: LB, LH, LW, LBU, LHU, SB, SH, SW.
- Checks alignment, then drives a request/grant/rvalid memory handshake.
- Steers byte lanes and sign/zero-extends load data.
- Returns a single-cycle response pulse to writeback, with optional timeout and flush abort.

Parameters:
TIMEOUT_CYCLES, 64, max cycles in REQ+WAIT before bus error; 0 disables timeout
CNT_W, $clog2(TIMEOUT_CYCLES+1), timeout counter width (derived, not overridden)

Ports:
clk_i  in  1  core clock
rst_i  in  1  asynchronous, active-high reset
req_valid_i  in  1  EX presents a memory op
req_ready_o  out  1  controller can accept (state IDLE)
op_i  in  operation_e  decoded operation
addr_i  in  32  effective byte address
wdata_i  in  32  store data (rs2)
rd_addr_i  in  5  load destination register
flush_i  in  1  abort in-flight op (trap/redirect)
dmem_req_o  out  1  memory request
dmem_we_o  out  1  1=store
dmem_be_o  out  4  byte enables
dmem_addr_o  out  32  word-aligned address
dmem_wdata_o  out  32  lane-replicated store data
dmem_gnt_i  in  1  request accepted
dmem_rvalid_i  in  1  load data valid
dmem_rdata_i  in  32  load data word
rsp_valid_o  out  1  one-cycle completion pulse
rsp_rdata_o  out  32  extended load result (0 for stores/errors)
rsp_rd_addr_o  out  5  destination register (0 for stores)
misalign_o  out  1  qualifies rsp_valid_o: misaligned access
bus_err_o  out  1  qualifies rsp_valid_o: timeout, or op not a load/store
fault_addr_o  out  32  byte address of the faulting access

Behaviour:
- Reset: state IDLE; all outputs 0 except req_ready_o=1; counter 0. Reset mid-transaction drops it with no response.
- States: IDLE, REQ, WAIT, DRAIN.
- Accept: req_valid_i && req_ready_o. Operands are registered; all dmem_* outputs are registered.
- Misaligned at accept (H with addr[0]=1; W with addr[1:0]≠0):
  - no memory request is issued;
  - next cycle: rsp_valid_o=1, misalign_o=1, fault_addr_o=addr_i;
  - stay in IDLE.
- Non-memory op at accept: same as misaligned, but bus_err_o=1 instead of misalign_o.
- Aligned op: IDLE→REQ.
  - dmem_req_o=1 from the cycle after accept.
  - dmem_addr_o={addr[31:2],2'b00}.
  - dmem_req_o, dmem_we_o, dmem_be_o, dmem_addr_o and dmem_wdata_o are held stable until dmem_gnt_i.
- Byte enables, by access width:
  - B: be=1<<addr[1:0], wdata={4{byte}}.
  - H: be=addr[1]?1100:0011, wdata={2{half}}.
  - W: be=1111.
- REQ on dmem_gnt_i: dmem_req_o drops next cycle.
  - Store → IDLE; rsp_valid_o pulses next cycle.
  - Load → WAIT.
- A same-cycle gnt and rvalid in REQ is legal; it completes the load directly.
- WAIT on dmem_rvalid_i:
  - select the lane by addr[1:0];
  - LB/LH sign-extend, LBU/LHU zero-extend;
  - rsp_valid_o, rsp_rdata_o and rsp_rd_addr_o are driven next cycle; state → IDLE.
- Timeout (TIMEOUT_CYCLES>0):
  - counter clears on entering REQ and increments each cycle in REQ/WAIT.
  - When it reaches TIMEOUT_CYCLES without completion: response with bus_err_o=1, fault_addr_o=addr.
  - From REQ: dmem_req_o deasserts, state → IDLE.
  - From WAIT: state → DRAIN.
- Flush has priority over gnt, rvalid and timeout in the same cycle; it never produces a response.
  - IDLE: no effect; an accept in the same cycle is discarded.
  - REQ without gnt: dmem_req_o deasserts next cycle, state → IDLE.
  - REQ with gnt: a store is dropped, state → IDLE; a load goes to DRAIN.
  - WAIT: state → DRAIN.
- DRAIN: wait for dmem_rvalid_i, discard the data, state → IDLE. The timeout does not apply in DRAIN.
- rsp_valid_o is exactly one cycle wide. Response fields hold their values until the next response.
- Throughput: at most one outstanding memory transaction.

Decomposition:
- kamus_pkg gains lsu_state_e (IDLE, REQ, WAIT, DRAIN).
- It also gains a helper function op_to_width returning the existing mem_width_e, and op_is_load/op_is_store predicates.
- Sub-module kamus_lsu_align (combinational) holds byte-enable and wdata replication plus load-lane extraction and extension; it is reused by the future store buffer.

Test Plan:
- SW addr=0x1000_0008 wdata=0xDEADBEEF, gnt after 2 cycles → dmem_be_o=1111, dmem_addr_o=0x1000_0008, req held 3 cycles; rsp_valid_o the cycle after gnt with rsp_rd_addr_o=0.
- LB addr=0x…0003, rdata=0x80AA_BBCC, rvalid 1 cycle after gnt → be=1000, rsp_rdata_o=0xFFFF_FF80; the same access as LBU → 0x0000_0080.
- LH addr=0x…0001 → no dmem_req_o ever; next cycle rsp_valid_o=1, misalign_o=1, fault_addr_o=0x…0001.
- TIMEOUT_CYCLES=4, gnt never asserted → bus_err_o with rsp_valid_o 4 cycles after REQ entry; req_ready_o=1 the cycle after.
- LW granted, flush_i asserted in WAIT, rvalid 3 cycles later → no rsp_valid_o; req_ready_o rises the cycle after rvalid.
- rst_i asserted asynchronously in WAIT → all outputs 0 immediately except req_ready_o=1; a later rvalid is ignored.
